// File: rtl/uart_pkg.sv
// Shared UART constants, receiver state encoding and baud arithmetic.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        WAIT_IDLE = 3'd0,
        IDLE      = 3'd1,
        START     = 3'd2,
        DATA      = 3'd3,
        PARITY    = 3'd4,
        STOP      = 3'd5
    } rx_state_t;

    function automatic int cycles_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/fifo_sync.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
module fifo_sync #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 10
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] head_reg;
    logic             pop, push, bypass;

    assign pop         = rd_en && (count_reg != '0);
    assign push        = wr_en && ((count_reg != CW'(DEPTH)) || pop);
    assign rd_ptr_next = pop ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
    // The written word becomes the new head only when nothing older remains.
    assign bypass      = push && ((count_reg == '0) || ((count_reg == CW'(1)) && pop));

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + 1'b1;
        end else if (pop && !push) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            head_reg   <= bypass ? wr_data : mem[rd_ptr_next];
        end
    end

    assign rd_valid = (count_reg != '0);
    assign rd_data  = rd_valid ? head_reg : '0;
    assign full     = (count_reg == CW'(DEPTH));
    assign count    = count_reg;

endmodule

// File: rtl/uart_rx_fifo.sv
// Configurable UART receiver; each frame is queued with its parity/framing flags.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ    = 12_000_000,
    parameter int BAUD_RATE   = 38_400,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 1,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                            sysclk,
    input  logic                            rst,
    input  logic                            uart_txd_in,
    output logic [DATA_BITS-1:0]            rd_data,
    output logic                            rd_perr,
    output logic                            rd_ferr,
    output logic                            rd_valid,
    input  logic                            rd_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
    output logic                            overflow,
    input  logic                            clear_err
);
    localparam int CYCLES_PER_BIT = cycles_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int SAMPLE_POINT   = CYCLES_PER_BIT / 2;
    localparam int TW             = $clog2(CYCLES_PER_BIT);
    localparam int BW             = $clog2(DATA_BITS+1);

    logic                 sync1_reg, rxs_reg;
    rx_state_t            state_reg, state_next;
    logic [TW-1:0]        tick_reg, tick_next;
    logic [BW-1:0]        bitcnt_reg, bitcnt_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic                 perr_reg, perr_next, ferr_reg, ferr_next;
    logic                 overflow_reg;
    logic                 tick_zero, frame_done, parity_exp, fifo_full, pop, drop;
    logic [DATA_BITS+1:0] fifo_rd;

    assign tick_zero  = (tick_reg == '0);
    assign parity_exp = (PARITY_MODE == PARITY_ODD) ? ~^shift_reg : ^shift_reg;

    always_comb begin
        state_next  = state_reg;
        tick_next   = tick_reg;
        bitcnt_next = bitcnt_reg;
        shift_next  = shift_reg;
        perr_next   = perr_reg;
        ferr_next   = ferr_reg;
        frame_done  = 1'b0;
        case (state_reg)
            WAIT_IDLE: if (rxs_reg) state_next = IDLE;
            IDLE: begin
                if (!rxs_reg) begin
                    tick_next  = TW'(SAMPLE_POINT - 1);
                    state_next = START;
                end
            end
            START: begin
                if (!tick_zero) begin
                    tick_next = tick_reg - 1'b1;
                end else if (rxs_reg) begin
                    state_next = IDLE;
                end else begin
                    tick_next   = TW'(CYCLES_PER_BIT - 1);
                    bitcnt_next = '0;
                    perr_next   = 1'b0;
                    ferr_next   = 1'b0;
                    state_next  = DATA;
                end
            end
            DATA: begin
                if (!tick_zero) begin
                    tick_next = tick_reg - 1'b1;
                end else begin
                    shift_next = {rxs_reg, shift_reg[DATA_BITS-1:1]};
                    tick_next  = TW'(CYCLES_PER_BIT - 1);
                    if (bitcnt_reg == BW'(DATA_BITS - 1)) begin
                        bitcnt_next = '0;
                        state_next  = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
                    end else begin
                        bitcnt_next = bitcnt_reg + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (!tick_zero) begin
                    tick_next = tick_reg - 1'b1;
                end else begin
                    perr_next  = (rxs_reg != parity_exp);
                    tick_next  = TW'(CYCLES_PER_BIT - 1);
                    state_next = STOP;
                end
            end
            STOP: begin
                if (!tick_zero) begin
                    tick_next = tick_reg - 1'b1;
                end else begin
                    tick_next = TW'(CYCLES_PER_BIT - 1);
                    if (!rxs_reg) ferr_next = 1'b1;
                    // Leave at mid-stop so a back-to-back start edge is not missed.
                    if (bitcnt_reg == BW'(STOP_BITS - 1)) begin
                        frame_done = 1'b1;
                        state_next = ferr_next ? WAIT_IDLE : IDLE;
                    end else begin
                        bitcnt_next = bitcnt_reg + 1'b1;
                    end
                end
            end
            default: state_next = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            sync1_reg  <= 1'b1;
            rxs_reg    <= 1'b1;
            state_reg  <= WAIT_IDLE;
            tick_reg   <= '0;
            bitcnt_reg <= '0;
            shift_reg  <= '0;
            perr_reg   <= 1'b0;
            ferr_reg   <= 1'b0;
        end else begin
            sync1_reg  <= uart_txd_in;
            rxs_reg    <= sync1_reg;
            state_reg  <= state_next;
            tick_reg   <= tick_next;
            bitcnt_reg <= bitcnt_next;
            shift_reg  <= shift_next;
            perr_reg   <= perr_next;
            ferr_reg   <= ferr_next;
        end
    end

    assign pop  = rd_valid && rd_ready;
    assign drop = frame_done && fifo_full && !pop;

    always_ff @(posedge sysclk) begin
        if (rst) begin
            overflow_reg <= 1'b0;
        end else if (drop) begin
            overflow_reg <= 1'b1;
        end else if (clear_err) begin
            overflow_reg <= 1'b0;
        end
    end

    fifo_sync #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS + 2)
    ) u_fifo (
        .clk      (sysclk),
        .srst     (rst),
        .wr_en    (frame_done),
        .wr_data  ({ferr_next, perr_reg, shift_reg}),
        .rd_en    (rd_ready),
        .rd_data  (fifo_rd),
        .rd_valid (rd_valid),
        .full     (fifo_full),
        .count    (count)
    );

    assign rd_data  = fifo_rd[DATA_BITS-1:0];
    assign rd_perr  = fifo_rd[DATA_BITS];
    assign rd_ferr  = fifo_rd[DATA_BITS+1];
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: an 8E1 and a 7O2 instance driven from a queue-based frame model.
module tb_uart_rx_fifo;
    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 100_000;
    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int SP       = CPB / 2;
    localparam int DEPTH    = 16;

    logic       sysclk = 1'b0;
    logic       rst;
    logic [1:0] line, rdy, clr;
    wire  [7:0] d0;
    wire  [6:0] d1;
    wire  [1:0] perr, ferr, vld, ovf;
    wire  [4:0] cnt0, cnt1;

    always #5 sysclk = ~sysclk;

    uart_rx_fifo #(
        .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(8),
        .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
    ) u_dut0 (
        .sysclk(sysclk), .rst(rst), .uart_txd_in(line[0]),
        .rd_data(d0), .rd_perr(perr[0]), .rd_ferr(ferr[0]), .rd_valid(vld[0]),
        .rd_ready(rdy[0]), .count(cnt0), .overflow(ovf[0]), .clear_err(clr[0])
    );

    uart_rx_fifo #(
        .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(7),
        .PARITY_MODE(2), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)
    ) u_dut1 (
        .sysclk(sysclk), .rst(rst), .uart_txd_in(line[1]),
        .rd_data(d1), .rd_perr(perr[1]), .rd_ferr(ferr[1]), .rd_valid(vld[1]),
        .rd_ready(rdy[1]), .count(cnt1), .overflow(ovf[1]), .clear_err(clr[1])
    );

    int          cur = 0;
    int          nbits_data = 8;
    int          pmode = 1;
    int          nstop = 1;
    int          compared = 0;
    int          mismatched = 0;
    logic [10:0] mq[$];
    logic        ov_exp = 1'b0;

    function automatic logic [10:0] obs_entry();
        if (cur == 1) return {ferr[1], perr[1], 2'b00, d1};
        return {ferr[0], perr[0], 1'b0, d0};
    endfunction

    function automatic logic [4:0] obs_count();
        return (cur == 1) ? cnt1 : cnt0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, ".valid"}, 32'(vld[cur]), 32'(mq.size() != 0));
        check({tag, ".count"}, 32'(obs_count()), 32'(mq.size()));
        check({tag, ".overflow"}, 32'(ovf[cur]), 32'(ov_exp));
        if (mq.size() != 0) check({tag, ".head"}, 32'(obs_entry()), 32'(mq[0]));
    endtask

    // Parity bit a correct transmitter would put on the line.
    function automatic logic par_bit(input logic [8:0] data);
        int ones;
        ones = $countones(data);
        return (pmode == 1) ? logic'(ones % 2) : logic'(1 - (ones % 2));
    endfunction

    task automatic send_frame(input string tag, input logic [8:0] data_in, input bit bad_par,
                              input bit bad_stop, input bit pop_at_push);
        logic        bits[$];
        logic [8:0]  mask, data;
        logic [10:0] ent;
        int          e;
        mask = 9'((1 << nbits_data) - 1);
        data = data_in & mask;
        bits.push_back(1'b0);
        for (int i = 0; i < nbits_data; i++) bits.push_back(data[i]);
        if (pmode != 0) bits.push_back(par_bit(data) ^ bad_par);
        for (int i = 0; i < nstop; i++) bits.push_back(!bad_stop);
        // Edge index (from the start-bit drive edge) of the last stop-bit sample.
        e = SP + 3 + (bits.size() - 1) * CPB;
        if (bad_stop) begin
            bits.push_back(1'b0);
            bits.push_back(1'b0);
        end
        for (int c = 0; c < bits.size() * CPB; c++) begin
            @(posedge sysclk); #1;
            if (pop_at_push && c == e - 1) check({tag, ".prepush_head"}, 32'(obs_entry()), 32'(mq[0]));
            if (pop_at_push && c == e) begin
                check({tag, ".push_cycle_count"}, 32'(obs_count()), 32'(DEPTH));
                check({tag, ".push_cycle_ovf"}, 32'(ovf[cur]), 32'(ov_exp));
            end
            line[cur] = bits[c / CPB];
            rdy[cur]  = pop_at_push && (c == e - 1);
        end
        @(posedge sysclk); #1;
        line[cur] = 1'b1;
        repeat (2 * CPB) @(posedge sysclk);
        #1;
        ent = {bad_stop, (pmode != 0) && bad_par, data};
        if (pop_at_push && mq.size() != 0) void'(mq.pop_front());
        if (mq.size() < DEPTH) mq.push_back(ent);
        else ov_exp = 1'b1;
        check_status(tag);
    endtask

    task automatic pop_one(input string tag);
        @(posedge sysclk); #1;
        rdy[cur] = 1'b1;
        @(posedge sysclk); #1;
        rdy[cur] = 1'b0;
        if (mq.size() != 0) void'(mq.pop_front());
        check_status(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge sysclk);
        #1;
        rst = 1'b0;
        mq.delete();
        ov_exp = 1'b0;
        repeat (4) @(posedge sysclk);
        #1;
    endtask

    task automatic clear_overflow(input string tag);
        clr[cur] = 1'b1;
        @(posedge sysclk); #1;
        clr[cur] = 1'b0;
        ov_exp = 1'b0;
        check_status(tag);
    endtask

    task automatic random_traffic(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            send_frame(tag, 9'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0, 1'b0);
            while (mq.size() != 0 && ($urandom_range(0, 2) == 0 || mq.size() >= 12)) pop_one({tag, ".pop"});
        end
        while (mq.size() != 0) pop_one({tag, ".drain"});
    endtask

    task automatic overflow_scenario(input string tag);
        for (int i = 0; i < DEPTH + 1; i++) send_frame({tag, ".fill"}, 9'($urandom), 1'b0, 1'b0, 1'b0);
        check({tag, ".full_count"}, 32'(obs_count()), 32'(DEPTH));
        check({tag, ".sticky"}, 32'(ovf[cur]), 32'd1);
        clear_overflow({tag, ".clear"});
        send_frame({tag, ".push_pop"}, 9'($urandom), 1'b0, 1'b0, 1'b1);
        while (mq.size() != 0) pop_one({tag, ".drain"});
        pop_one({tag, ".pop_empty"});
    endtask

    initial begin
        rst  = 1'b0;
        line = 2'b11;
        rdy  = 2'b00;
        clr  = 2'b00;
        do_reset();
        check_status("reset");
        check("reset.data", 32'(d0), 32'd0);
        check("reset.flags", 32'({perr[0], ferr[0]}), 32'd0);

        send_frame("t1", 9'h0AA, 1'b0, 1'b0, 1'b0);
        pop_one("t1.pop");

        send_frame("t2.a", 9'h0AA, 1'b0, 1'b0, 1'b0);
        send_frame("t2.b", 9'h032, 1'b0, 1'b0, 1'b0);
        send_frame("t2.c", 9'h000, 1'b0, 1'b0, 1'b0);
        send_frame("t2.d", 9'h05C, 1'b0, 1'b0, 1'b0);
        repeat (4) pop_one("t2.pop");

        send_frame("t3.bad", 9'h032, 1'b1, 1'b0, 1'b0);
        send_frame("t3.good", 9'h032, 1'b0, 1'b0, 1'b0);
        repeat (2) pop_one("t3.pop");

        send_frame("t4.ferr", 9'h05C, 1'b0, 1'b1, 1'b0);
        send_frame("t4.next", 9'h000, 1'b0, 1'b0, 1'b0);
        repeat (2) pop_one("t4.pop");

        // Short low pulse on an idle line must not start a frame.
        @(posedge sysclk); #1;
        line[cur] = 1'b0;
        repeat (SP / 2) @(posedge sysclk);
        #1;
        line[cur] = 1'b1;
        repeat (3 * CPB) @(posedge sysclk);
        #1;
        check_status("t5.glitch");

        send_frame("t5.pre", 9'h0C3, 1'b0, 1'b0, 1'b0);
        @(posedge sysclk); #1;
        line[cur] = 1'b0;
        repeat (4 * CPB) @(posedge sysclk);
        #1;
        line[cur] = 1'b1;
        do_reset();
        check_status("t5.rst_mid");
        send_frame("t5.after", 9'h0A5, 1'b0, 1'b0, 1'b0);
        pop_one("t5.pop");

        random_traffic("rand8e1", 20);
        overflow_scenario("t6.8e1");

        cur        = 1;
        nbits_data = 7;
        pmode      = 2;
        nstop      = 2;
        do_reset();
        check_status("b.reset");
        send_frame("b.perr", 9'h032, 1'b1, 1'b0, 1'b0);
        send_frame("b.ferr", 9'h05C, 1'b0, 1'b1, 1'b0);
        repeat (2) pop_one("b.pop");
        random_traffic("rand7o2", 12);
        overflow_scenario("t6.7o2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
